// File: rtl/uart_byte_link.sv
// uart_byte_link: 8N1 UART byte transport with receive FIFO and trig/done handshakes
// Ports: in_clk, in_rst_n (async active-low) | uart_rx (async serial in), uart_tx (serial out, idle high)
//        data_rx/rx_done (delivered byte + 1-cycle pulse), rx_trig (request next byte)
//        data_tx/tx_trig (byte + start pulse), tx_done (frame sent pulse)
//        rx_overrun (sticky drop flag), rx_frame_err (bad stop/parity pulse)
// Optional: define UART_LINK_PARITY_EN for 8E1 framing.
module uart_byte_link #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] data_rx,
  output logic       rx_done,
  input  logic       rx_trig,
  input  logic [7:0] data_tx,
  input  logic       tx_trig,
  output logic       tx_done,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int DIV_RAW = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int DIV = DIV_RAW < 4 ? 4 : DIV_RAW;
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  logic rx_s1, rx_s2, rx_s3;
  rx_state_t r_st, r_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic r_tick, fall, push, ferr, perr;
  logic [7:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic armed, full, deliver, push_ok;
  tx_state_t t_st, t_nxt;
  logic [CW-1:0] t_cnt;
  logic [2:0] t_bit;
  logic [7:0] t_sh;
  logic t_tick;
  assign fall = rx_s3 & ~rx_s2;
  // start bit is re-checked at its midpoint; every later bit is sampled a full period on
  assign r_tick = r_cnt == (r_st == R_START ? HALF : LAST);
`ifdef UART_LINK_PARITY_EN
  logic r_perr, t_par;
  assign perr = r_perr;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      r_perr <= 1'b0;
      t_par <= 1'b0;
    end else begin
      if (r_st == R_IDLE) r_perr <= 1'b0;
      else if (r_st == R_PAR && r_tick) r_perr <= rx_s2 ^ (^r_sh);
      if (t_st == T_IDLE && tx_trig) t_par <= ^data_tx;
    end
  assign uart_tx = t_st == T_START ? 1'b0 : t_st == T_DATA ? t_sh[0] : t_st == T_PAR ? t_par : 1'b1;
`else
  assign perr = 1'b0;
  assign uart_tx = t_st == T_START ? 1'b0 : t_st == T_DATA ? t_sh[0] : 1'b1;
`endif
  always_comb begin
    r_nxt = r_st;
    push = 1'b0;
    ferr = 1'b0;
    case (r_st)
      R_IDLE: r_nxt = fall ? R_START : R_IDLE;
      R_START: if (r_tick) r_nxt = rx_s2 ? R_IDLE : R_DATA;
`ifdef UART_LINK_PARITY_EN
      R_DATA: if (r_tick && r_bit == 3'd7) r_nxt = R_PAR;
      R_PAR: if (r_tick) r_nxt = R_STOP;
`else
      R_DATA: if (r_tick && r_bit == 3'd7) r_nxt = R_STOP;
`endif
      R_STOP: if (r_tick) begin
        r_nxt = R_IDLE;
        push = rx_s2 & ~perr;
        ferr = ~rx_s2 | perr;
      end
      default: r_nxt = R_IDLE;
    endcase
  end
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      {rx_s3, rx_s2, rx_s1} <= 3'b111;
      r_st <= R_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, uart_rx};
      r_st <= r_nxt;
      r_cnt <= (r_nxt != r_st || r_tick || r_st == R_IDLE) ? '0 : r_cnt + CW'(1);
      if (r_st == R_IDLE) r_bit <= '0;
      else if (r_st == R_DATA && r_tick) r_bit <= r_bit + 3'd1;
      if (r_st == R_DATA && r_tick) r_sh <= {rx_s2, r_sh[7:1]};
      rx_frame_err <= ferr;
    end
  assign full = count == (AW + 1)'(RX_FIFO_DEPTH);
  assign deliver = armed && count != '0;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign push_ok = push && (!full || deliver);
  always_ff @(posedge in_clk)
    if (push_ok) mem[wr_ptr] <= r_sh;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      armed <= 1'b1;
      data_rx <= '0;
      rx_done <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (deliver) begin
        rd_ptr <= rd_ptr + AW'(1);
        data_rx <= mem[rd_ptr];
      end
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, deliver};
      // delivery consumes the old armed value; a same-cycle rx_trig re-arms for the next byte
      armed <= deliver ? rx_trig : armed | rx_trig;
      rx_done <= deliver;
      rx_overrun <= rx_overrun | (push & ~push_ok);
    end
  assign t_tick = t_cnt == LAST;
  always_comb begin
    t_nxt = t_st;
    case (t_st)
      T_IDLE: t_nxt = tx_trig ? T_START : T_IDLE;
      T_START: if (t_tick) t_nxt = T_DATA;
`ifdef UART_LINK_PARITY_EN
      T_DATA: if (t_tick && t_bit == 3'd7) t_nxt = T_PAR;
      T_PAR: if (t_tick) t_nxt = T_STOP;
`else
      T_DATA: if (t_tick && t_bit == 3'd7) t_nxt = T_STOP;
`endif
      T_STOP: if (t_tick) t_nxt = T_IDLE;
      default: t_nxt = T_IDLE;
    endcase
  end
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      t_st <= T_IDLE;
      t_cnt <= '0;
      t_bit <= '0;
      t_sh <= '0;
      tx_done <= 1'b0;
    end else begin
      t_st <= t_nxt;
      t_cnt <= (t_nxt != t_st || t_tick || t_st == T_IDLE) ? '0 : t_cnt + CW'(1);
      if (t_st == T_IDLE) t_bit <= '0;
      else if (t_st == T_DATA && t_tick) t_bit <= t_bit + 3'd1;
      if (t_st == T_IDLE && tx_trig) t_sh <= data_tx;
      else if (t_st == T_DATA && t_tick) t_sh <= t_sh >> 1;
      tx_done <= t_st == T_STOP && t_tick;
    end
endmodule
